clk_gate_ctrl: RTL and testbench

Idle-timeout controller that drives the enable of a downstream latch-based clock gate. It sits in the always-on clock domain, directly upstream of the gate cell's enable input. It watches a peripheral's busy flag and software policy bits. After a programmable number of idle cycles it deasserts the enable. On a wake event it re-enables the clock and holds a settle window before reporting the domain ready.

---
 rtl/clk_gate_ctrl.sv | 121 ++++++++++++
 tb/tb_clk_gate_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Idle-timeout controller for a latch-based clock gate enable.
// Gates after a programmable idle run and re-enables with a settle window on wake.
module clk_gate_ctrl #(
  parameter int CNT_W    = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sleep_en_i,
  input  logic             force_on_i,
  input  logic             busy_i,
  input  logic             wake_req_i,
  input  logic [CNT_W-1:0] idle_thresh_i,
  output logic             clk_en_o,
  output logic             ready_o,
  output logic             wake_ack_o,
  output logic [1:0]       state_o
);

  // state | meaning
  // RUN   | clock on, domain ready, waiting for idle
  // DRAIN | clock on, counting idle cycles toward the threshold
  // GATED | clock off, waiting for a wake condition
  // WAKE  | clock on, settling before ready is reported
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  localparam logic [CNT_W:0] WAKE_LAT_W = (CNT_W+1)'(WAKE_LAT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             ready_q, ready_d;
  logic             wake_ack_q, wake_ack_d;

  logic             idle;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   thresh_ext;

  assign idle       = sleep_en_i & ~force_on_i & ~busy_i & ~wake_req_i;
  // One extra bit so the compare-before-increment never sees a wrapped value.
  assign cnt_inc    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign thresh_ext = {1'b0, idle_thresh_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (idle) begin
          state_d = (idle_thresh_i == '0) ? ST_GATED : ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (!idle) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_inc >= thresh_ext) begin
          state_d = ST_GATED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      ST_GATED: begin
        if (!idle) begin
          state_d = (WAKE_LAT == 0) ? ST_RUN : ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        // Inputs are ignored here; the settle window always runs to completion.
        if (cnt_inc >= WAKE_LAT_W) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they move with state_q.
  always_comb begin
    clk_en_d   = (state_d != ST_GATED);
    ready_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    wake_ack_d = (state_d == ST_RUN) &&
                 ((state_q == ST_GATED) || (state_q == ST_WAKE));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      clk_en_q   <= 1'b1;
      ready_q    <= 1'b1;
      wake_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_en_q   <= clk_en_d;
      ready_q    <= ready_d;
      wake_ack_q <= wake_ack_d;
    end
  end

  assign clk_en_o   = clk_en_q;
  assign ready_o    = ready_q;
  assign wake_ack_o = wake_ack_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: three instances (WAKE_LAT 2/0/4) share stimulus and
// are compared every cycle against a queued reference model plus directed checks.
module tb_clk_gate_ctrl;
  localparam int CNT_W = 8;
  localparam int N     = 3;

  logic                 clk_i = 1'b0;
  logic                 rst_i, sleep_en_i, force_on_i, busy_i, wake_req_i;
  logic [CNT_W-1:0]     idle_thresh_i;
  logic [N-1:0]         clk_en, ready, ack;
  logic [N-1:0][1:0]    st;

  int lat_tab [N] = '{2, 0, 4};
  int m_st    [N] = '{0, 0, 0};
  int m_cnt   [N] = '{0, 0, 0};

  typedef struct {
    int         inst;
    logic [4:0] exp;
  } exp_t;
  exp_t sb [$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk_i = ~clk_i;

  clk_gate_ctrl #(.CNT_W(CNT_W), .WAKE_LAT(2)) u_lat2 (
    .clk_i(clk_i), .rst_i(rst_i), .sleep_en_i(sleep_en_i), .force_on_i(force_on_i),
    .busy_i(busy_i), .wake_req_i(wake_req_i), .idle_thresh_i(idle_thresh_i),
    .clk_en_o(clk_en[0]), .ready_o(ready[0]), .wake_ack_o(ack[0]), .state_o(st[0]));

  clk_gate_ctrl #(.CNT_W(CNT_W), .WAKE_LAT(0)) u_lat0 (
    .clk_i(clk_i), .rst_i(rst_i), .sleep_en_i(sleep_en_i), .force_on_i(force_on_i),
    .busy_i(busy_i), .wake_req_i(wake_req_i), .idle_thresh_i(idle_thresh_i),
    .clk_en_o(clk_en[1]), .ready_o(ready[1]), .wake_ack_o(ack[1]), .state_o(st[1]));

  clk_gate_ctrl #(.CNT_W(CNT_W), .WAKE_LAT(4)) u_lat4 (
    .clk_i(clk_i), .rst_i(rst_i), .sleep_en_i(sleep_en_i), .force_on_i(force_on_i),
    .busy_i(busy_i), .wake_req_i(wake_req_i), .idle_thresh_i(idle_thresh_i),
    .clk_en_o(clk_en[2]), .ready_o(ready[2]), .wake_ack_o(ack[2]), .state_o(st[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] obs(input int i);
    return {clk_en[i], ready[i], ack[i], st[i]};
  endfunction

  // Predict the post-edge outputs from the current inputs, then clock and compare.
  task automatic step();
    logic       idle;
    exp_t       e;
    int         nst, ncnt;
    logic [4:0] x;
    idle = sleep_en_i & ~force_on_i & ~busy_i & ~wake_req_i;
    for (int i = 0; i < N; i++) begin
      nst  = m_st[i];
      ncnt = m_cnt[i];
      if (rst_i) begin
        nst = 0; ncnt = 0;
      end else begin
        case (m_st[i])
          0: if (idle) begin nst = (idle_thresh_i == 0) ? 2 : 1; ncnt = 0; end
          1: begin
            if (!idle) begin nst = 0; ncnt = 0; end
            else if (m_cnt[i] + 1 >= int'(idle_thresh_i)) begin nst = 2; ncnt = 0; end
            else ncnt = m_cnt[i] + 1;
          end
          2: if (!idle) begin nst = (lat_tab[i] == 0) ? 0 : 3; ncnt = 0; end
          default: begin
            if (m_cnt[i] + 1 >= lat_tab[i]) begin nst = 0; ncnt = 0; end
            else ncnt = m_cnt[i] + 1;
          end
        endcase
      end
      x[4]   = (nst != 2);
      x[3]   = (nst < 2);
      x[2]   = !rst_i && (nst == 0) && (m_st[i] >= 2);
      x[1:0] = nst[1:0];
      e.inst = i;
      e.exp  = x;
      sb.push_back(e);
      m_st[i]  = nst;
      m_cnt[i] = ncnt;
    end
    @(posedge clk_i);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("model_i%0d_c%0d", e.inst, cyc), 32'(obs(e.inst)), 32'(e.exp));
    end
    cyc++;
  endtask

  task automatic resync();
    rst_i = 1'b0; force_on_i = 1'b0; wake_req_i = 1'b0; busy_i = 1'b1;
    repeat (8) step();
  endtask

  initial begin
    rst_i = 1'b1; sleep_en_i = 1'b1; force_on_i = 1'b0; busy_i = 1'b0;
    wake_req_i = 1'b0; idle_thresh_i = 8'd5;
    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset_clk_en_i%0d", i), 32'(clk_en[i]), 1);
      chk($sformatf("reset_ready_i%0d", i),  32'(ready[i]), 1);
      chk($sformatf("reset_ack_i%0d", i),    32'(ack[i]), 0);
      chk($sformatf("reset_state_i%0d", i),  32'(st[i]), 0);
    end

    // Threshold gating, T=5
    rst_i = 1'b0; busy_i = 1'b1;
    repeat (2) step();
    busy_i = 1'b0;
    step();
    chk("drain_entry_state", 32'(st[0]), 1);
    repeat (4) step();
    chk("pre_gate_clk_en", 32'(clk_en[0]), 1);
    step();
    chk("gate_clk_en", 32'(clk_en[0]), 0);
    chk("gate_ready", 32'(ready[0]), 0);
    chk("gate_state", 32'(st[0]), 2);
    repeat (2) step();

    // Wake sequence
    wake_req_i = 1'b1;
    step();
    chk("wake_clk_en", 32'(clk_en[0]), 1);
    chk("wake_ready_low", 32'(ready[0]), 0);
    chk("wake_state", 32'(st[0]), 3);
    chk("lat0_ready", 32'(ready[1]), 1);
    chk("lat0_ack", 32'(ack[1]), 1);
    chk("lat0_state", 32'(st[1]), 0);
    wake_req_i = 1'b0;
    step();
    chk("wake_mid_ready", 32'(ready[0]), 0);
    chk("lat0_ack_once", 32'(ack[1]), 0);
    step();
    chk("wake_done_ready", 32'(ready[0]), 1);
    chk("wake_done_ack", 32'(ack[0]), 1);
    chk("wake_done_state", 32'(st[0]), 0);
    step();
    chk("wake_ack_pulse", 32'(ack[0]), 0);
    chk("wake_then_drain", 32'(st[0]), 1);

    // Drain abort by a single busy edge
    resync();
    busy_i = 1'b0;
    repeat (3) step();
    busy_i = 1'b1;
    step();
    chk("abort_state", 32'(st[0]), 0);
    chk("abort_clk_en", 32'(clk_en[0]), 1);
    busy_i = 1'b0;
    repeat (5) step();
    chk("regate_pre_clk_en", 32'(clk_en[0]), 1);
    step();
    chk("regate_clk_en", 32'(clk_en[0]), 0);

    // T=0 gates on the first idle edge
    resync();
    idle_thresh_i = 8'd0;
    busy_i = 1'b0;
    step();
    chk("t0_clk_en", 32'(clk_en[0]), 0);
    chk("t0_state", 32'(st[0]), 2);

    // force_on on the edge DRAIN would gate
    resync();
    idle_thresh_i = 8'd5;
    busy_i = 1'b0;
    repeat (5) step();
    force_on_i = 1'b1;
    step();
    chk("force_state", 32'(st[0]), 0);
    chk("force_clk_en", 32'(clk_en[0]), 1);

    // Threshold shrink mid-drain
    resync();
    idle_thresh_i = 8'd200;
    busy_i = 1'b0;
    repeat (51) step();
    chk("shrink_pre_state", 32'(st[0]), 1);
    idle_thresh_i = 8'd10;
    step();
    chk("shrink_state", 32'(st[0]), 2);

    // Reset on the second WAKE edge of the WAKE_LAT=4 instance
    resync();
    idle_thresh_i = 8'd0;
    busy_i = 1'b0;
    step();
    wake_req_i = 1'b1;
    step();
    chk("rw_wake_state", 32'(st[2]), 3);
    step();
    rst_i = 1'b1;
    step();
    chk("rw_state", 32'(st[2]), 0);
    chk("rw_ready", 32'(ready[2]), 1);
    chk("rw_ack", 32'(ack[2]), 0);
    chk("rw_clk_en", 32'(clk_en[2]), 1);
    rst_i = 1'b0; wake_req_i = 1'b0;
    step();
    chk("rw_regate", 32'(st[2]), 2);
    wake_req_i = 1'b1;
    step();
    wake_req_i = 1'b0;
    repeat (3) step();
    chk("rw_settle_ready", 32'(ready[2]), 0);
    step();
    chk("rw_full_lat_ready", 32'(ready[2]), 1);
    chk("rw_full_lat_ack", 32'(ack[2]), 1);

    // Random traffic against the model
    repeat (400) begin
      rst_i         = ($urandom_range(0, 49) == 0);
      sleep_en_i    = ($urandom_range(0, 7) != 0);
      force_on_i    = ($urandom_range(0, 15) == 0);
      busy_i        = ($urandom_range(0, 7) == 0);
      wake_req_i    = ($urandom_range(0, 15) == 0);
      idle_thresh_i = 8'($urandom_range(0, 6));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
